// File: rtl/seq_transmitter.sv
// ============================================================================
//  Module   : seq_transmitter
//  Brief    : Serial framer: preamble, then payload MSB-first, then idle gap.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module seq_transmitter #(
  parameter int              DATA_W   = 8,
  parameter int              PRE_W    = 3,
  parameter logic [PRE_W-1:0] PREAMBLE = 3'b101,
  parameter int              GAP      = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              load_valid,
  output logic              load_ready,
  output logic              bit_out,
  output logic              bit_valid,
  output logic              busy,
  output logic              frame_done
);

  localparam int c_max_pd = (PRE_W > DATA_W) ? PRE_W : DATA_W;
  localparam int c_max    = (c_max_pd > GAP) ? c_max_pd : GAP;
  localparam int CNT_W    = $clog2(c_max + 1);
  localparam int SH_W     = PRE_W + DATA_W;

  localparam logic [CNT_W-1:0] c_one       = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_pre_last  = CNT_W'(PRE_W - 1);
  localparam logic [CNT_W-1:0] c_data_last = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] c_gap_last  = CNT_W'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PRE  = 2'd1,
    S_DATA = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [SH_W-1:0]   r_shift;
  logic              r_load_ready;
  logic              r_bit_out;
  logic              r_bit_valid;
  logic              r_busy;
  logic              r_frame_done;

  // Preamble and payload share one shift register; the first preamble bit is
  // driven straight from the parameter so it appears the cycle after accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_shift      <= '0;
      r_load_ready <= 1'b1;
      r_bit_out    <= 1'b0;
      r_bit_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (load_valid && r_load_ready) begin
            r_state      <= S_PRE;
            r_cnt        <= c_pre_last;
            r_shift      <= {PREAMBLE, data_in} << 1;
            r_bit_out    <= PREAMBLE[PRE_W-1];
            r_bit_valid  <= 1'b1;
            r_busy       <= 1'b1;
            r_load_ready <= 1'b0;
          end
        end
        S_PRE: begin
          r_bit_out <= r_shift[SH_W-1];
          r_shift   <= r_shift << 1;
          if (r_cnt == '0) begin
            r_state <= S_DATA;
            r_cnt   <= c_data_last;
          end else begin
            r_cnt <= r_cnt - c_one;
          end
        end
        S_DATA: begin
          if (r_cnt == '0) begin
            r_bit_out    <= 1'b0;
            r_bit_valid  <= 1'b0;
            r_frame_done <= 1'b1;
            if (GAP > 0) begin
              r_state <= S_GAP;
              r_cnt   <= c_gap_last;
            end else begin
              r_state      <= S_IDLE;
              r_cnt        <= '0;
              r_busy       <= 1'b0;
              r_load_ready <= 1'b1;
            end
          end else begin
            r_bit_out <= r_shift[SH_W-1];
            r_shift   <= r_shift << 1;
            r_cnt     <= r_cnt - c_one;
          end
        end
        default: begin
          if (r_cnt == '0) begin
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
            r_load_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt - c_one;
          end
        end
      endcase
    end
  end

  assign load_ready = r_load_ready;
  assign bit_out    = r_bit_out;
  assign bit_valid  = r_bit_valid;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;

endmodule

`default_nettype wire

// File: tb/tb_seq_transmitter.sv
// ============================================================================
//  Module   : tb_seq_transmitter
//  Brief    : Directed vector table plus multi-cycle sequences for the framer.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_seq_transmitter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic       load_valid;
  logic       load_ready, bit_out, bit_valid, busy, frame_done;

  logic [7:0] data_in0;
  logic       load_valid0;
  logic       load_ready0, bit_out0, bit_valid0, busy0, frame_done0;

  always #5 clk = ~clk;

  seq_transmitter dut (
    .clk(clk), .rst(rst), .data_in(data_in), .load_valid(load_valid),
    .load_ready(load_ready), .bit_out(bit_out), .bit_valid(bit_valid),
    .busy(busy), .frame_done(frame_done)
  );

  seq_transmitter #(.GAP(0)) dut0 (
    .clk(clk), .rst(rst), .data_in(data_in0), .load_valid(load_valid0),
    .load_ready(load_ready0), .bit_out(bit_out0), .bit_valid(bit_valid0),
    .busy(busy0), .frame_done(frame_done0)
  );

  int vectors = 0;
  int miscompares = 0;

  int cyc = 0;
  int fd_cnt = 0;
  int n0 = 0;
  int starts [4];
  logic prev0 = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frame_done === 1'b1) fd_cnt <= fd_cnt + 1;
    prev0 <= bit_valid0;
    if (bit_valid0 === 1'b1 && prev0 !== 1'b1 && n0 < 4) begin
      starts[n0] <= cyc;
      n0 <= n0 + 1;
    end
  end

  typedef struct {
    logic       rst;
    logic       lv;
    logic [7:0] d;
    logic       bo, bv, bsy, fd, rdy;
  } vec_t;

  vec_t tbl[$];

  function automatic void push(input logic r, lv, input logic [7:0] d,
                               input logic bo, bv, bsy, fd, rdy);
    vec_t v;
    v.rst = r; v.lv = lv; v.d = d;
    v.bo = bo; v.bv = bv; v.bsy = bsy; v.fd = fd; v.rdy = rdy;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for the first valid bit of the next frame.
  task automatic wait_first_bit(output int waited);
    waited = 0;
    while (bit_valid !== 1'b1 && waited < 40) begin
      step();
      waited++;
    end
    chk("first_bit_timeout", 32'(bit_valid === 1'b1), 32'd1);
  endtask

  // Called in the first valid-bit cycle; leaves off in the frame_done cycle.
  task automatic grab(output logic [10:0] bits);
    bits = '0;
    for (int j = 0; j < 11; j++) begin
      if (bit_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL grab_valid: bit %0d got bit_valid=%b, want 1", j, bit_valid);
      end
      bits = {bits[9:0], bit_out};
      step();
    end
    chk("grab_frame_done", 32'(frame_done), 32'd1);
    chk("grab_tail_valid", 32'(bit_valid), 32'd0);
    chk("grab_tail_bit", 32'(bit_out), 32'd0);
  endtask

  initial begin
    logic [10:0] f_a5;
    logic [10:0] b;
    int          w;
    int          fd_base;

    rst = 1'b1; load_valid = 1'b0; data_in = 8'h00;
    load_valid0 = 1'b0; data_in0 = 8'h00;

    // Reset with load_valid high, then one A5 frame; data_in changes after accept.
    f_a5 = 11'b101_10100101;
    push(1, 1, 8'hA5, 0, 0, 0, 0, 1);
    push(1, 1, 8'hA5, 0, 0, 0, 0, 1);
    push(0, 1, 8'hA5, 1, 1, 1, 0, 0);
    for (int j = 9; j >= 0; j--) push(0, 0, 8'h00, f_a5[j], 1, 1, 0, 0);
    push(0, 0, 8'h00, 0, 0, 1, 1, 0);
    push(0, 0, 8'h00, 0, 0, 1, 0, 0);
    push(0, 0, 8'h00, 0, 0, 0, 0, 1);
    push(0, 0, 8'h00, 0, 0, 0, 0, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst; load_valid = tbl[i].lv; data_in = tbl[i].d;
      step();
      chk($sformatf("v%0d_bit_out", i),    32'(bit_out),    32'(tbl[i].bo));
      chk($sformatf("v%0d_bit_valid", i),  32'(bit_valid),  32'(tbl[i].bv));
      chk($sformatf("v%0d_busy", i),       32'(busy),       32'(tbl[i].bsy));
      chk($sformatf("v%0d_frame_done", i), 32'(frame_done), 32'(tbl[i].fd));
      chk($sformatf("v%0d_load_ready", i), 32'(load_ready), 32'(tbl[i].rdy));
    end

    // Load offered while busy must wait for load_ready.
    data_in = 8'hFF; load_valid = 1'b1;
    step();
    load_valid = 1'b0; data_in = 8'h00;
    fork
      grab(b);
      begin
        repeat (5) @(posedge clk);
        #2;
        load_valid = 1'b1; data_in = 8'h3C;
      end
    join
    chk("busy_ff_frame", 32'(b), 32'(11'b101_11111111));
    wait_first_bit(w);
    chk("busy_accept_delay", 32'(w), 32'd3);
    load_valid = 1'b0; data_in = 8'h00;
    grab(b);
    chk("busy_3c_frame", 32'(b), 32'(11'b101_00111100));
    repeat (3) step();

    // Reset during the 5th serial bit.
    fd_base = fd_cnt;
    data_in = 8'h5A; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    repeat (4) step();
    chk("midrst_in_frame", 32'(bit_valid), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_valid", 32'(bit_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ready", 32'(load_ready), 32'd1);
    chk("midrst_bit", 32'(bit_out), 32'd0);
    repeat (15) begin
      step();
      if (bit_valid !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL midrst_quiet: bit_valid=%b busy=%b, want 0 0", bit_valid, busy);
      end
    end
    chk("midrst_no_done", 32'(fd_cnt - fd_base), 32'd0);
    data_in = 8'hC3; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    grab(b);
    chk("midrst_next_frame", 32'(b), 32'(11'b101_11000011));
    repeat (3) step();

    // Back-to-back frames with load_valid held high.
    fd_base = fd_cnt;
    data_in = 8'h00; load_valid = 1'b1;
    step();
    data_in = 8'hFF;
    grab(b);
    chk("b2b_frame0", 32'(b), 32'(11'b101_00000000));
    wait_first_bit(w);
    chk("b2b_idle_gap", 32'(w), 32'd3);
    load_valid = 1'b0;
    grab(b);
    chk("b2b_frame1", 32'(b), 32'(11'b101_11111111));
    repeat (4) step();
    chk("b2b_done_pulses", 32'(fd_cnt - fd_base), 32'd2);

    // GAP=0 instance: held load_valid yields a 12-cycle frame period.
    data_in0 = 8'h00; load_valid0 = 1'b1;
    for (int i = 0; i < 60 && n0 < 3; i++) step();
    chk("gap0_frames_seen", 32'(n0 >= 3), 32'd1);
    if (n0 >= 3) begin
      chk("gap0_period_a", 32'(starts[1] - starts[0]), 32'd12);
      chk("gap0_period_b", 32'(starts[2] - starts[1]), 32'd12);
    end
    load_valid0 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
